request_latch: RTL and testbench
================================

Name: request_latch

Overview:
- Upstream front end of the elevator controller; directly feeds the movement FSM.
- Synchronises and debounces the 3 interior and 3 exterior call buttons, and converts each clean press into a sticky per-floor request bit.
- Clears a floor's request when the movement FSM reports that floor's door open.
- Drives the request vector consumed by the movement FSM, plus button-lamp, new-request and pending-count outputs.

Parameters:
- DB_CYCLES, 4: consecutive cycles a synchronised input must differ from its debounced value before that value flips. Legal range 1..(2^DB_W - 1).
- DB_W, 3: width of each debounce counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- interior_panel  input  3  cabin buttons; bit2 = floor 3, bit0 = floor 1; raw, asynchronous.
- exterior_panel  input  3  hall buttons; same bit order; raw, asynchronous.
- doors  input  3  door status from the movement FSM; one bit per floor; 1 = open.
- requests  output  3  latched pending requests; bit2 = floor 3.
- lamps  output  3  button indicator lamps; registered copy equal to requests.
- new_request  output  1  one-cycle pulse when any request bit goes 0->1.
- pending_count  output  2  population count of requests (0..3).

Behaviour:
- Reset:
  - RST high clears, asynchronously: all synchroniser flops, debounced values, debounce counters, edge-detect flops, requests, lamps, new_request and pending_count.
  - All outputs read 0 while RST is high and on the first edge after release.
  - Reset mid-operation discards all pending requests and in-progress debounce counts.
- Synchroniser:
  - Each of the 6 inputs passes through two flops (s1 -> s2) before any other logic sees it.
- Debounce, per input:
  - Each input has a counter cnt and a debounced value stb.
  - If s2 == stb: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stb <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DB_CYCLES cycles never changes stb.
- Press detect:
  - stb_d is stb registered one cycle.
  - press = stb & ~stb_d, a one-cycle event per 0->1 transition of stb.
  - A held button produces exactly one press. The button must be debounced-released and pressed again to produce another.
- Floor press:
  - fpress[i] = int_press[i] | ext_press[i].
  - Simultaneous interior and exterior presses for the same floor count as one.
- Request register, per floor i, every edge:
  - If doors[i] == 1: requests[i] <= 0. Clear wins over a simultaneous press; a press at a floor whose door is open is discarded.
  - Else if fpress[i]: requests[i] <= 1.
  - Else: requests[i] holds.
  - Requests for different floors are independent; any combination may be set in the same cycle.
- Outputs:
  - lamps <= next value of requests, so lamps equals requests every cycle.
  - new_request <= 1 for one cycle when (next requests & ~requests) != 0. A press on an already-set bit does not pulse.
  - pending_count <= popcount(next requests); updates on the same edge as requests.
- Latency with DB_CYCLES = 4:
  - Raw input rising before edge 1 is captured in s1 at edge 1 and s2 at edge 2.
  - stb flips at edge 6; requests, lamps, new_request and pending_count update at edge 7.
  - General case: requests update at edge DB_CYCLES+3.
- doors:
  - Treated as synchronous to CLK; no synchroniser.
  - More than one doors bit high is legal; each clears its own floor.

Test Plan:
- Reset: assert RST mid-debounce with floor-2 request pending -> all outputs 0 immediately; after release, no spurious request or new_request.
- Clean press: interior_panel = 3'b100 held 10 cycles, doors = 0, DB_CYCLES = 4 -> requests = 3'b100 at edge 7, new_request high exactly at edge 7, pending_count = 1; no further pulses while held.
- Glitch rejection: exterior_panel[0] high for 3 cycles then low -> requests stays 3'b000, new_request never asserts.
- Clear and priority: requests = 3'b011, then doors = 3'b001 for 1 cycle -> requests = 3'b010, pending_count = 1. With doors[1] = 1 held, press floor 2 -> requests[1] stays 0, no new_request.
- Simultaneous sources: interior floor 1 and exterior floors 1 and 3 pressed in the same cycle -> requests = 3'b101 on one edge, one new_request pulse, pending_count = 2.
- Re-press: requests[2] set, cleared by doors[2], button released past debounce then pressed again -> requests[2] re-sets with a new pulse after DB_CYCLES+3 edges.

Source files
------------

// File: rtl/request_latch.sv
// Call-button front end for the elevator controller: synchronises and debounces
// the six raw buttons and keeps one sticky request bit per floor until its door opens.
module request_latch #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] interior_panel,
    input  logic [2:0] exterior_panel,
    input  logic [2:0] doors,
    output logic [2:0] requests,
    output logic [2:0] lamps,
    output logic       new_request,
    output logic [1:0] pending_count
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE = DB_W'(1);

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Buttons are handled as one vector: bits 2:0 interior, bits 5:3 exterior.
    logic [5:0]      raw_s;
    logic [5:0]      s1_q;
    logic [5:0]      s2_q;
    logic [5:0]      stb_q;
    logic [5:0]      stb_d;
    logic [5:0]      stb_dly_q;
    logic [DB_W-1:0] cnt_q [6];
    logic [DB_W-1:0] cnt_d [6];
    logic [5:0]      press_s;
    logic [2:0]      fpress_s;
    logic [2:0]      req_q;
    logic [2:0]      req_d;
    logic [2:0]      lamps_q;
    logic            new_q;
    logic            new_d;
    logic [1:0]      pend_q;

    assign raw_s = {exterior_panel, interior_panel};

    // Debounce: stb follows s2 only after it has disagreed for DB_CYCLES cycles.
    always_comb begin
        stb_d = stb_q;
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                stb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    assign press_s  = stb_q & ~stb_dly_q;
    assign fpress_s = press_s[2:0] | press_s[5:3];

    // An open door clears its floor and swallows any press arriving with it.
    always_comb begin
        req_d = req_q;
        for (int i = 0; i < 3; i++) begin
            if (doors[i]) begin
                req_d[i] = 1'b0;
            end else if (fpress_s[i]) begin
                req_d[i] = 1'b1;
            end else begin
                req_d[i] = req_q[i];
            end
        end
    end

    assign new_d = |(req_d & ~req_q);

    // Input synchroniser, debounce state and press edge detector.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q      <= 6'b000000;
            s2_q      <= 6'b000000;
            stb_q     <= 6'b000000;
            stb_dly_q <= 6'b000000;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= raw_s;
            s2_q      <= s1_q;
            stb_q     <= stb_d;
            stb_dly_q <= stb_q;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Request register and its registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_q   <= 3'b000;
            lamps_q <= 3'b000;
            new_q   <= 1'b0;
            pend_q  <= 2'b00;
        end else begin
            req_q   <= req_d;
            lamps_q <= req_d;
            new_q   <= new_d;
            pend_q  <= popcount3(req_d);
        end
    end

    assign requests      = req_q;
    assign lamps         = lamps_q;
    assign new_request   = new_q;
    assign pending_count = pend_q;

endmodule

// File: tb/tb_request_latch.sv
// Directed self-checking bench for request_latch with DB_CYCLES = 4.
module tb_request_latch;

    logic       CLK;
    logic       RST;
    logic [2:0] interior_panel;
    logic [2:0] exterior_panel;
    logic [2:0] doors;
    logic [2:0] requests;
    logic [2:0] lamps;
    logic       new_request;
    logic [1:0] pending_count;

    int n_cmp;
    int n_err;
    int pulses;

    request_latch #(.DB_CYCLES(4), .DB_W(3)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .interior_panel (interior_panel),
        .exterior_panel (exterior_panel),
        .doors          (doors),
        .requests       (requests),
        .lamps          (lamps),
        .new_request    (new_request),
        .pending_count  (pending_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] req, input logic nr, input logic [1:0] pc);
        chk({tag, "_req"}, {29'd0, requests}, {29'd0, req});
        chk({tag, "_lamps"}, {29'd0, lamps}, {29'd0, req});
        chk({tag, "_new"}, {31'd0, new_request}, {31'd0, nr});
        chk({tag, "_pend"}, {30'd0, pending_count}, {30'd0, pc});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST = 1'b1;
        interior_panel = 3'b000;
        exterior_panel = 3'b000;
        doors = 3'b000;

        // Reset state and first edge after release
        tick();
        tick();
        chk_all("rst_hold", 3'b000, 1'b0, 2'd0);
        RST = 1'b0;
        tick();
        chk_all("rst_rel", 3'b000, 1'b0, 2'd0);

        // Clean interior press of floor 3: request appears on edge 7
        interior_panel = 3'b100;
        for (int k = 1; k <= 6; k++) tick();
        chk_all("clean_e6", 3'b000, 1'b0, 2'd0);
        tick();
        chk_all("clean_e7", 3'b100, 1'b1, 2'd1);
        pulses = 0;
        for (int k = 8; k <= 10; k++) begin
            tick();
            pulses += int'(new_request);
        end
        chk("clean_held_pulses", pulses, 0);
        interior_panel = 3'b000;
        for (int k = 0; k < 8; k++) tick();
        chk_all("clean_release", 3'b100, 1'b0, 2'd1);

        // Door clear then re-press of floor 3
        doors = 3'b100;
        tick();
        doors = 3'b000;
        chk_all("repress_clr", 3'b000, 1'b0, 2'd0);
        interior_panel = 3'b100;
        for (int k = 1; k <= 6; k++) tick();
        chk_all("repress_e6", 3'b000, 1'b0, 2'd0);
        tick();
        chk_all("repress_e7", 3'b100, 1'b1, 2'd1);
        interior_panel = 3'b000;
        for (int k = 0; k < 8; k++) tick();
        doors = 3'b100;
        tick();
        doors = 3'b000;
        chk_all("repress_clr2", 3'b000, 1'b0, 2'd0);

        // Glitch of 3 cycles on exterior floor 1 is rejected
        exterior_panel = 3'b001;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            pulses += int'(new_request);
        end
        exterior_panel = 3'b000;
        for (int k = 0; k < 12; k++) begin
            tick();
            pulses += int'(new_request);
        end
        chk("glitch_pulses", pulses, 0);
        chk_all("glitch_end", 3'b000, 1'b0, 2'd0);

        // Build requests = 011, then clear floor 1 with doors[0]
        interior_panel = 3'b011;
        for (int k = 1; k <= 7; k++) tick();
        chk_all("set011", 3'b011, 1'b1, 2'd2);
        interior_panel = 3'b000;
        for (int k = 0; k < 8; k++) tick();
        doors = 3'b001;
        tick();
        doors = 3'b000;
        chk_all("clr_f1", 3'b010, 1'b0, 2'd1);

        // Held door at floor 2 clears it and discards a press there
        doors = 3'b010;
        tick();
        chk_all("door2_clr", 3'b000, 1'b0, 2'd0);
        interior_panel = 3'b010;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            pulses += int'(new_request);
        end
        chk("door2_pulses", pulses, 0);
        chk_all("door2_press", 3'b000, 1'b0, 2'd0);
        interior_panel = 3'b000;
        for (int k = 0; k < 8; k++) tick();
        doors = 3'b000;
        tick();
        chk_all("door2_after", 3'b000, 1'b0, 2'd0);

        // Interior floor 1 with exterior floors 1 and 3 in the same cycle
        interior_panel = 3'b001;
        exterior_panel = 3'b101;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            pulses += int'(new_request);
            if (k == 6) chk_all("simul_e6", 3'b000, 1'b0, 2'd0);
            if (k == 7) chk_all("simul_e7", 3'b101, 1'b1, 2'd2);
        end
        chk("simul_pulses", pulses, 1);
        interior_panel = 3'b000;
        exterior_panel = 3'b000;
        for (int k = 0; k < 8; k++) tick();
        chk_all("simul_hold", 3'b101, 1'b0, 2'd2);

        // Reset mid-debounce of floor 2 with requests pending
        interior_panel = 3'b010;
        for (int k = 0; k < 3; k++) tick();
        RST = 1'b1;
        #1;
        chk_all("midrst_async", 3'b000, 1'b0, 2'd0);
        interior_panel = 3'b000;
        tick();
        chk_all("midrst_hold", 3'b000, 1'b0, 2'd0);
        RST = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            pulses += int'(new_request);
        end
        chk("midrst_pulses", pulses, 0);
        chk_all("midrst_after", 3'b000, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
